// File: rtl/word_slice_serializer.sv
// Down-sizing gearbox: latches an IN_W-bit word and streams it out as RATIO
// lanes of OUT_W bits in MSB-first, LSB-first, auto or single-lane order.
module word_slice_serializer #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int RATIO = IN_W / OUT_W;
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(RATIO - 1);

  generate
    if (RATIO < 2 || (IN_W % OUT_W) != 0) begin : g_bad_cfg
      $error("word_slice_serializer: IN_W must be a multiple of OUT_W with ratio >= 2");
    end
  endgenerate

  typedef enum logic {IDLE, EMIT} state_t;

  state_t state_q, state_d;

  logic [IN_W-1:0]  word_q, word_d;
  logic             lsb_q, lsb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;

  logic [RATIO-1:0][OUT_W-1:0] in_lanes, word_lanes;
  logic          accept, take, auto_a, load_lsb, load_single;
  logic [CW-1:0] nxt_pos, nxt_idx;

  assign in_lanes   = in_data;
  assign word_lanes = word_q;

  assign in_ready = !out_valid_q | (out_ready & out_last_q);
  assign accept   = in_valid & in_ready;
  assign take     = out_valid_q & out_ready;

  // Single-lane mode reuses the order flag: lane 0 is the first LSB-first
  // lane, lane RATIO-1 the first MSB-first lane; out_last is set on load.
  assign auto_a      = in_data[IN_W-1] & in_data[OUT_W];
  assign load_lsb    = (in_mode == 2'b01) | (in_mode[1] & auto_a);
  assign load_single = (in_mode == 2'b11);

  assign nxt_pos = cnt_q + 1'b1;
  assign nxt_idx = lsb_q ? nxt_pos : (LAST_IDX - nxt_pos);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      word_q      <= '0;
      lsb_q       <= 1'b0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      lsb_q       <= lsb_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = EMIT;
      EMIT: if (take && out_last_q && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values; a load always wins so the last-lane
  // handshake and the next acceptance share one edge without a bubble.
  always_comb begin
    word_d      = word_q;
    lsb_d       = lsb_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    if (accept) begin
      word_d      = in_data;
      lsb_d       = load_lsb;
      cnt_d       = '0;
      out_data_d  = load_lsb ? in_lanes[0] : in_lanes[RATIO-1];
      out_valid_d = 1'b1;
      out_last_d  = load_single;
    end else if (state_q == EMIT && take) begin
      if (!out_last_q) begin
        cnt_d      = nxt_pos;
        out_data_d = word_lanes[nxt_idx];
        out_last_d = (nxt_pos == LAST_IDX);
      end else begin
        cnt_d       = '0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = out_valid_q;

endmodule

// File: tb/tb_word_slice_serializer.sv
// Directed bench: 16/8 instance for ordering, streaming, stall and reset;
// a 32/8 instance for the wide auto-order case.
module tb_word_slice_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_busy;
  logic [15:0] a_in_data;
  logic [1:0]  a_in_mode;
  logic [7:0]  a_out_data;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_busy;
  logic [31:0] b_in_data;
  logic [1:0]  b_in_mode;
  logic [7:0]  b_out_data;

  int checks = 0;
  int errors = 0;

  word_slice_serializer #(.IN_W(16), .OUT_W(8)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_last(a_out_last), .busy(a_busy)
  );

  word_slice_serializer #(.IN_W(32), .OUT_W(8)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [7:0] d, input logic last, input logic rdy);
    chk({tag, " valid"}, {31'd0, a_out_valid}, 32'd1);
    chk({tag, " data"}, {24'd0, a_out_data}, {24'd0, d});
    chk({tag, " last"}, {31'd0, a_out_last}, {31'd0, last});
    chk({tag, " in_ready"}, {31'd0, a_in_ready}, {31'd0, rdy});
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, " idle valid"}, {31'd0, a_out_valid}, 32'd0);
    chk({tag, " idle busy"}, {31'd0, a_busy}, 32'd0);
    chk({tag, " idle in_ready"}, {31'd0, a_in_ready}, 32'd1);
  endtask

  // Called at a negedge with dut_a idle; returns at a negedge with it idle again.
  task automatic run_word(input string tag, input logic [1:0] mode, input logic [15:0] data,
                          input int n, input logic [7:0] e0, input logic [7:0] e1);
    a_in_valid = 1'b1; a_in_data = data; a_in_mode = mode;
    @(negedge clk);
    a_in_valid = 1'b0; a_in_data = 16'hFFFF; a_in_mode = ~mode;
    chk_a({tag, " lane0"}, e0, n == 1, n == 1);
    if (n == 2) begin
      @(negedge clk);
      chk_a({tag, " lane1"}, e1, 1'b1, 1'b1);
    end
    @(negedge clk);
    chk_idle_a(tag);
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_in_mode = 2'b00; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_mode = 2'b00; b_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst out_data", {24'd0, a_out_data}, 32'd0);
    chk("rst out_last", {31'd0, a_out_last}, 32'd0);
    chk_idle_a("rst");
    chk("rst b valid", {31'd0, b_out_valid}, 32'd0);
    chk("rst b in_ready", {31'd0, b_in_ready}, 32'd1);

    // Basic MSB-first, auto both ways, single-lane both ways
    run_word("m00 1234", 2'b00, 16'h1234, 2, 8'h12, 8'h34);
    run_word("m10 81AB", 2'b10, 16'h81AB, 2, 8'hAB, 8'h81);
    run_word("m10 01AB", 2'b10, 16'h01AB, 2, 8'h01, 8'hAB);
    run_word("m11 81AB", 2'b11, 16'h81AB, 1, 8'hAB, 8'h00);
    run_word("m11 7FCD", 2'b11, 16'h7FCD, 1, 8'h7F, 8'h00);
    run_word("m01 1234", 2'b01, 16'h1234, 2, 8'h34, 8'h12);

    // Back-to-back LSB-first: no bubble, in_ready only on last lanes
    a_in_valid = 1'b1; a_in_data = 16'hAAAA; a_in_mode = 2'b01;
    @(negedge clk);
    a_in_data = 16'h5555;
    chk_a("b2b w0l0", 8'hAA, 1'b0, 1'b0);
    @(negedge clk);
    chk_a("b2b w0l1", 8'hAA, 1'b1, 1'b1);
    @(negedge clk);
    a_in_valid = 1'b0;
    chk_a("b2b w1l0", 8'h55, 1'b0, 1'b0);
    @(negedge clk);
    chk_a("b2b w1l1", 8'h55, 1'b1, 1'b1);
    @(negedge clk);
    chk_idle_a("b2b");

    // Backpressure: out_ready 1 at accept, then 0, 0, 1
    a_in_valid = 1'b1; a_in_data = 16'hBEEF; a_in_mode = 2'b00;
    @(negedge clk);
    a_in_valid = 1'b0; a_out_ready = 1'b0;
    chk_a("bp s0", 8'hBE, 1'b0, 1'b0);
    @(negedge clk);
    chk_a("bp s1", 8'hBE, 1'b0, 1'b0);
    @(negedge clk);
    a_out_ready = 1'b1;
    chk_a("bp s2", 8'hBE, 1'b0, 1'b0);
    @(negedge clk);
    chk_a("bp l1", 8'hEF, 1'b1, 1'b1);
    @(negedge clk);
    chk_idle_a("bp");

    // Reset mid-word, then a clean word
    a_in_valid = 1'b1; a_in_data = 16'hCAFE; a_in_mode = 2'b00;
    @(negedge clk);
    a_in_valid = 1'b0;
    chk_a("mid l0", 8'hCA, 1'b0, 1'b0);
    @(negedge clk);
    chk_a("mid l1", 8'hFE, 1'b1, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid rst data", {24'd0, a_out_data}, 32'd0);
    chk("mid rst last", {31'd0, a_out_last}, 32'd0);
    chk_idle_a("mid rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_word("post 0102", 2'b00, 16'h0102, 2, 8'h01, 8'h02);

    // 32/8 auto order, mode and data scrambled during emission
    b_in_valid = 1'b1; b_in_data = 32'h8000_0100; b_in_mode = 2'b10;
    @(negedge clk);
    b_in_valid = 1'b0; b_in_data = 32'h1234_5678; b_in_mode = 2'b00;
    chk("w32 l0", {23'd0, b_out_valid, b_out_data, b_out_last}, {23'd0, 1'b1, 8'h00, 1'b0});
    chk("w32 l0 rdy", {31'd0, b_in_ready}, 32'd0);
    @(negedge clk);
    chk("w32 l1", {23'd0, b_out_valid, b_out_data, b_out_last}, {23'd0, 1'b1, 8'h01, 1'b0});
    @(negedge clk);
    chk("w32 l2", {23'd0, b_out_valid, b_out_data, b_out_last}, {23'd0, 1'b1, 8'h00, 1'b0});
    @(negedge clk);
    chk("w32 l3", {23'd0, b_out_valid, b_out_data, b_out_last}, {23'd0, 1'b1, 8'h80, 1'b1});
    chk("w32 l3 rdy", {31'd0, b_in_ready}, 32'd1);
    @(negedge clk);
    chk("w32 idle", {30'd0, b_out_valid, b_busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/word_slice_serializer.md
# word_slice_serializer

Parametrised down-sizing gearbox. It accepts an IN_W-bit word on a valid/ready input channel and emits it as IN_W/OUT_W lanes of OUT_W bits on a valid/ready output channel. Lane order is selectable per word: MSB-first, LSB-first, data-dependent auto order, or single-lane extract. It is the streaming successor of the fixed 16→8 word-slice block and sits between wide producer datapaths and byte-wide consumers.

## Interface
- IN_W, 16: input word width. Must be an integer multiple of OUT_W.
- OUT_W, 8: output lane width.
- RATIO (derived, not overridable): IN_W/OUT_W. Must be ≥2; elaboration fails otherwise.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  producer has a word.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  IN_W  word. Lane i = in_data[i*OUT_W +: OUT_W]; lane 0 is least significant.
- in_mode  in  2  ordering: 00 MSB-first, 01 LSB-first, 10 auto, 11 single-lane.
- out_valid  out  1  out_data holds a valid lane.
- out_ready  in  1  consumer accepts the lane.
- out_data  out  OUT_W  current lane.
- out_last  out  1  current lane is the final lane of its word.
- busy  out  1  a word is held (out_valid).

## Operation
- Auto predicate: A = in_data[IN_W-1] & in_data[OUT_W]. For the default configuration this is bit15 & bit8.
- Order per mode:
  - 00: lanes RATIO-1 … 0.
  - 01: lanes 0 … RATIO-1.
  - 10: LSB-first if A, else MSB-first.
  - 11: one lane only, lane 0 if A else lane RATIO-1, with out_last=1. This reproduces the legacy block's behaviour.
- Latching:
  - in_data and the resolved order are latched on acceptance (in_valid & in_ready).
  - in_mode and in_data changes after acceptance have no effect on the word in flight.
- States:
  - IDLE (out_valid=0).
  - EMIT (out_valid=1, lane counter cnt 0..N-1, where N=RATIO or 1 for single-lane mode).
- Transitions:
  - IDLE→EMIT on acceptance; cnt=0.
  - EMIT, out_ready & !out_last: cnt+1, next lane presented.
  - EMIT, out_ready & out_last & in_valid: new word loaded, stay EMIT, cnt=0. No bubble.
  - EMIT, out_ready & out_last & !in_valid: go to IDLE.
  - EMIT, !out_ready: hold out_data, out_last and cnt stable.
- in_ready = !out_valid | (out_ready & out_last). This is combinational from registered state and out_ready; there is no in_valid→in_ready path.
- out_last = (cnt == N-1) while in EMIT.
- Output registers: out_data, out_valid and out_last are registered.
- busy = out_valid.
- Reset (any time, including mid-word): out_valid=0, out_last=0, out_data=0, cnt=0, state IDLE, in_ready=1. The word in flight is discarded.

## Timing
- Latency: a word accepted at edge k presents its first lane from edge k until the lane is taken.
- Throughput: with out_ready held high, one lane per cycle. Sustained input rate is one word per RATIO cycles (one per cycle in single-lane mode).
- AXI-style rules apply:
  - Once out_valid=1, out_data and out_last stay stable until out_ready.
  - out_valid never drops without a handshake, except under rst.
- The last-lane handshake and the next-word acceptance occur at the same edge.

## Test plan
- Reset release; defaults 16/8; mode 00; in_data=0x1234 accepted; out_ready=1. Required: out_data 0x12 then 0x34 on consecutive cycles, out_last on 0x34, then out_valid=0. Before acceptance: out_data=0x00, in_ready=1.
- Mode 10 with 0x81AB (A=1) → 0xAB, 0x81. Mode 10 with 0x01AB (A=0) → 0x01, 0xAB. Mode 11 with 0x81AB → single 0xAB with out_last=1. Mode 11 with 0x7FCD → single 0x7F.
- Back-to-back, mode 01: 0xAAAA then 0x5555 presented continuously with out_ready=1. Required: 4 lanes on 4 consecutive cycles with no bubble, and in_ready high exactly on the out_last cycles.
- Backpressure: out_ready toggled 1,0,0,1 during word 0xBEEF in mode 00. Required: 0xBE held stable through the stall, no lane lost or duplicated, and in_ready=0 throughout.
- Reset mid-word: assert rst after the first lane of 0xCAFE. Required: outputs at reset values immediately; the next word 0x0102 (mode 00) emits 0x01, 0x02 with no residue.
- IN_W=32, OUT_W=8, mode 10, in_data=0x80000100 (A=1). Required: 0x00, 0x01, 0x00, 0x80 with out_last on 0x80. Mode changed during emission must not alter the order.
